// File: rtl/bp_counter_ctrl.sv
// Owner of the BP_RAM read/write ports: sweeps INIT_VAL after reset, serves
// zero-latency prediction lookups, and drains queued updates as single-cycle RMWs.
module bp_counter_ctrl #(
   parameter int DEPTH        = 64,
   parameter int INDEX        = 6,
   parameter int WIDTH        = 2,
   parameter int INIT_VAL     = 2,
   parameter int QDEPTH       = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pred_valid_i,
   input  logic [INDEX-1:0] pred_index_i,
   output logic             pred_ready_o,
   output logic             pred_taken_o,
   output logic [WIDTH-1:0] pred_ctr_o,
   input  logic             upd_valid_i,
   input  logic [INDEX-1:0] upd_index_i,
   input  logic             upd_taken_i,
   output logic             upd_ready_o,
   output logic             init_done_o,
   output logic [INDEX-1:0] ram_raddr_o,
   input  logic [WIDTH-1:0] ram_rdata_i,
   output logic [INDEX-1:0] ram_waddr_o,
   output logic [WIDTH-1:0] ram_wdata_o,
   output logic             ram_we_o
);

   localparam int QW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t           state_q, state_d;
   logic [INDEX-1:0] ptr_q, ptr_d;
   logic             init_done_q, init_done_d;
   logic [QW:0]      cnt_q, cnt_d;
   logic [QW-1:0]    wr_q, wr_d;
   logic [QW-1:0]    rd_q, rd_d;
   logic [SW-1:0]    starve_q, starve_d;
   logic [INDEX-1:0] q_idx_q [QDEPTH];
   logic [INDEX-1:0] q_idx_d [QDEPTH];
   logic             q_tk_q  [QDEPTH];
   logic             q_tk_d  [QDEPTH];

   logic             run, force_upd, grant, enq;
   logic [INDEX-1:0] head_idx;
   logic             head_tk;
   logic [WIDTH-1:0] next_ctr;

   assign pred_taken_o = ram_rdata_i[WIDTH-1];
   assign pred_ctr_o   = ram_rdata_i;
   assign init_done_o  = init_done_q;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      init_done_d = init_done_q;
      cnt_d       = cnt_q;
      wr_d        = wr_q;
      rd_d        = rd_q;
      starve_d    = starve_q;
      q_idx_d     = q_idx_q;
      q_tk_d      = q_tk_q;

      // Handshake outputs are held low while reset is asserted, even mid-run.
      run          = (state_q == ST_RUN) && !reset;
      force_upd    = (starve_q == SW'(STARVE_LIMIT));
      grant        = run && (cnt_q != '0) && (!pred_valid_i || force_upd);
      pred_ready_o = run && !force_upd;
      upd_ready_o  = run && (cnt_q < (QW+1)'(QDEPTH));
      enq          = upd_valid_i && upd_ready_o;

      head_idx = q_idx_q[rd_q];
      head_tk  = q_tk_q[rd_q];
      if (head_tk) next_ctr = (ram_rdata_i == '1) ? ram_rdata_i : ram_rdata_i + WIDTH'(1);
      else         next_ctr = (ram_rdata_i == '0) ? ram_rdata_i : ram_rdata_i - WIDTH'(1);

      ram_raddr_o = pred_index_i;
      ram_waddr_o = ptr_q;
      ram_wdata_o = WIDTH'(INIT_VAL);
      ram_we_o    = 1'b0;

      case (state_q)
         ST_INIT: begin
            if (!reset) begin
               ram_we_o = 1'b1;
               ptr_d    = ptr_q + INDEX'(1);
               if (ptr_q == INDEX'(DEPTH - 1)) begin
                  state_d     = ST_RUN;
                  init_done_d = 1'b1;
               end
            end
         end
         default: begin
            if (grant) begin
               ram_raddr_o = head_idx;
               ram_waddr_o = head_idx;
               ram_wdata_o = next_ctr;
               ram_we_o    = 1'b1;
               rd_d        = rd_q + QW'(1);
               starve_d    = '0;
            end else if (run && (cnt_q != '0) && pred_valid_i) begin
               starve_d = starve_q + SW'(1);
            end
         end
      endcase

      if (enq) begin
         q_idx_d[wr_q] = upd_index_i;
         q_tk_d[wr_q]  = upd_taken_i;
         wr_d          = wr_q + QW'(1);
      end

      case ({enq, grant})
         2'b10:   cnt_d = cnt_q + (QW+1)'(1);
         2'b01:   cnt_d = cnt_q - (QW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      q_idx_q <= q_idx_d;
      q_tk_q  <= q_tk_d;
      if (reset) begin
         state_q     <= ST_INIT;
         ptr_q       <= '0;
         init_done_q <= 1'b0;
         cnt_q       <= '0;
         wr_q        <= '0;
         rd_q        <= '0;
         starve_q    <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         init_done_q <= init_done_d;
         cnt_q       <= cnt_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         starve_q    <= starve_d;
      end
   end

endmodule

// File: tb/tb_bp_counter_ctrl.sv
// Bench for bp_counter_ctrl: directed scenarios plus a randomized run checked
// against a queue-and-table model of the counter table.
module tb_bp_counter_ctrl;

   localparam int DEPTH  = 64;
   localparam int INDEX  = 6;
   localparam int WIDTH  = 2;
   localparam int QDEPTH = 4;
   localparam int SLIM   = 8;

   logic             clk;
   logic             reset;
   logic             pred_valid_i;
   logic [INDEX-1:0] pred_index_i;
   logic             pred_ready_o;
   logic             pred_taken_o;
   logic [WIDTH-1:0] pred_ctr_o;
   logic             upd_valid_i;
   logic [INDEX-1:0] upd_index_i;
   logic             upd_taken_i;
   logic             upd_ready_o;
   logic             init_done_o;
   logic [INDEX-1:0] ram_raddr_o;
   logic [WIDTH-1:0] ram_rdata_i;
   logic [INDEX-1:0] ram_waddr_o;
   logic [WIDTH-1:0] ram_wdata_o;
   logic             ram_we_o;

   int errors;
   int checks;
   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] ram [DEPTH];

   bp_counter_ctrl #(.DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH), .INIT_VAL(2),
                     .QDEPTH(QDEPTH), .STARVE_LIMIT(SLIM)) dut (
      .clk(clk), .reset(reset),
      .pred_valid_i(pred_valid_i), .pred_index_i(pred_index_i),
      .pred_ready_o(pred_ready_o), .pred_taken_o(pred_taken_o), .pred_ctr_o(pred_ctr_o),
      .upd_valid_i(upd_valid_i), .upd_index_i(upd_index_i), .upd_taken_i(upd_taken_i),
      .upd_ready_o(upd_ready_o), .init_done_o(init_done_o),
      .ram_raddr_o(ram_raddr_o), .ram_rdata_i(ram_rdata_i),
      .ram_waddr_o(ram_waddr_o), .ram_wdata_o(ram_wdata_o), .ram_we_o(ram_we_o)
   );

   // BP_RAM: asynchronous read, write at the clock edge.
   assign ram_rdata_i = ram[ram_raddr_o];
   always @(posedge clk) if (ram_we_o) ram[ram_waddr_o] <= ram_wdata_o;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: got time limit, want $finish");
      $fatal(1);
   end

   // Inputs change 1 after the edge; outputs are sampled 3 later.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      pred_valid_i = 1'b0; pred_index_i = '0;
      upd_valid_i = 1'b0; upd_index_i = '0; upd_taken_i = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1; pred_valid_i = 1'b1; upd_valid_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #3;
         checks++; if (ram_we_o !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", ram_we_o); end
         checks++; if (init_done_o !== 1'b0) begin errors++; $display("FAIL rst_init_done: got %b want 0", init_done_o); end
         checks++; if (upd_ready_o !== 1'b0) begin errors++; $display("FAIL rst_upd_ready: got %b want 0", upd_ready_o); end
         checks++; if (pred_ready_o !== 1'b0) begin errors++; $display("FAIL rst_pred_ready: got %b want 0", pred_ready_o); end
         cycle();
      end
      reset = 1'b0; idle_inputs();
      for (int i = 0; i < DEPTH; i++) begin
         #3;
         checks++;
         if (ram_we_o !== 1'b1 || ram_waddr_o !== INDEX'(i) || ram_wdata_o !== WIDTH'(2)) begin
            errors++; $display("FAIL sweep[%0d]: got we=%b addr=%0d data=%0d want we=1 addr=%0d data=2", i, ram_we_o, ram_waddr_o, ram_wdata_o, i);
         end
         checks++; if (upd_ready_o !== 1'b0 || init_done_o !== 1'b0) begin errors++; $display("FAIL sweep_ctl[%0d]: got upd_ready=%b init_done=%b want 0 0", i, upd_ready_o, init_done_o); end
         cycle();
      end
      #3;
      checks++; if (init_done_o !== 1'b1) begin errors++; $display("FAIL init_done: got %b want 1", init_done_o); end
      checks++; if (upd_ready_o !== 1'b1 || pred_ready_o !== 1'b1) begin errors++; $display("FAIL run_ready: got upd=%b pred=%b want 1 1", upd_ready_o, pred_ready_o); end
      checks++; if (ram_we_o !== 1'b0) begin errors++; $display("FAIL run_idle_we: got %b want 0", ram_we_o); end
      for (int i = 0; i < DEPTH; i++) begin
         checks++; if (ram[i] !== WIDTH'(2)) begin errors++; $display("FAIL ram_init[%0d]: got %0d want 2", i, ram[i]); end
      end
      cycle();
   endtask

   task automatic test_saturation();
      logic [WIDTH-1:0] e;
      int idx, tk, n;
      for (int s = 0; s < 2; s++) begin
         idx = (s == 0) ? 5 : 9;
         tk  = (s == 0) ? 1 : 0;
         n   = (s == 0) ? 3 : 4;
         exp_q.delete();
         if (s == 0) begin exp_q.push_back(2'd3); exp_q.push_back(2'd3); exp_q.push_back(2'd3); end
         else begin exp_q.push_back(2'd1); exp_q.push_back(2'd0); exp_q.push_back(2'd0); exp_q.push_back(2'd0); end
         for (int c = 0; c < n + 4; c++) begin
            idle_inputs();
            upd_valid_i = (c < n); upd_index_i = INDEX'(idx); upd_taken_i = tk[0];
            #3;
            if (c < n) begin
               checks++; if (upd_ready_o !== 1'b1) begin errors++; $display("FAIL sat%0d_ready[%0d]: got %b want 1", s, c, upd_ready_o); end
            end
            if (ram_we_o === 1'b1) begin
               checks++;
               if (exp_q.size() == 0) begin errors++; $display("FAIL sat%0d_extra_write: got addr=%0d want none", s, ram_waddr_o); end
               else begin
                  e = exp_q.pop_front();
                  if (ram_waddr_o !== INDEX'(idx) || ram_wdata_o !== e) begin
                     errors++; $display("FAIL sat%0d_write: got addr=%0d data=%0d want addr=%0d data=%0d", s, ram_waddr_o, ram_wdata_o, idx, e);
                  end
               end
            end
            cycle();
         end
         checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sat%0d_writes: got %0d missing want 0", s, exp_q.size()); end
         idle_inputs(); pred_valid_i = 1'b1; pred_index_i = INDEX'(idx);
         #3;
         checks++;
         if (pred_ready_o !== 1'b1 || pred_ctr_o !== ((s == 0) ? 2'd3 : 2'd0) || pred_taken_o !== ((s == 0) ? 1'b1 : 1'b0)) begin
            errors++; $display("FAIL sat%0d_lookup: got ready=%b ctr=%0d taken=%b want 1 %0d %0d", s, pred_ready_o, pred_ctr_o, pred_taken_o, (s == 0) ? 3 : 0, (s == 0) ? 1 : 0);
         end
         cycle();
      end
      idle_inputs();
   endtask

   task automatic test_queue_full();
      int k;
      for (int c = 0; c < 13; c++) begin
         idle_inputs();
         pred_valid_i = 1'b1; pred_index_i = '0;
         upd_valid_i = (c < 5); upd_index_i = INDEX'(10 + c); upd_taken_i = 1'b1;
         #3;
         if (c < 5) begin
            checks++; if (upd_ready_o !== (c < 4)) begin errors++; $display("FAIL qfull_ready[%0d]: got %b want %b", c, upd_ready_o, (c < 4)); end
         end
         checks++; if (ram_we_o !== (c == 9)) begin errors++; $display("FAIL qfull_we[%0d]: got %b want %b", c, ram_we_o, (c == 9)); end
         checks++; if (pred_ready_o !== (c != 9)) begin errors++; $display("FAIL qfull_pred_ready[%0d]: got %b want %b", c, pred_ready_o, (c != 9)); end
         if (c == 0) begin
            checks++; if (pred_ctr_o !== 2'd2) begin errors++; $display("FAIL qfull_lookup: got %0d want 2", pred_ctr_o); end
         end
         if (c == 9) begin
            checks++; if (ram_waddr_o !== 6'd10 || ram_wdata_o !== 2'd3) begin errors++; $display("FAIL qfull_force_write: got addr=%0d data=%0d want 10 3", ram_waddr_o, ram_wdata_o); end
         end
         cycle();
      end
      k = 0;
      for (int c = 0; c < 6; c++) begin
         idle_inputs();
         #3;
         if (ram_we_o === 1'b1) begin
            checks++; if (ram_waddr_o !== INDEX'(11 + k) || ram_wdata_o !== 2'd3) begin errors++; $display("FAIL qfull_drain[%0d]: got addr=%0d data=%0d want %0d 3", k, ram_waddr_o, ram_wdata_o, 11 + k); end
            k++;
         end
         cycle();
      end
      checks++; if (k != 3) begin errors++; $display("FAIL qfull_drain_count: got %0d want 3", k); end
   endtask

   task automatic test_starvation();
      for (int c = 0; c < 22; c++) begin
         idle_inputs();
         pred_valid_i = 1'b1; pred_index_i = 6'd1;
         upd_valid_i = (c == 0 || c == 10); upd_index_i = 6'd30; upd_taken_i = 1'b0;
         #3;
         checks++; if (pred_ready_o !== !(c == 9 || c == 19)) begin errors++; $display("FAIL starve_pred_ready[%0d]: got %b want %b", c, pred_ready_o, !(c == 9 || c == 19)); end
         checks++; if (ram_we_o !== (c == 9 || c == 19)) begin errors++; $display("FAIL starve_we[%0d]: got %b want %b", c, ram_we_o, (c == 9 || c == 19)); end
         if (c == 9 || c == 19) begin
            checks++;
            if (ram_waddr_o !== 6'd30 || ram_wdata_o !== ((c == 9) ? 2'd1 : 2'd0)) begin
               errors++; $display("FAIL starve_write[%0d]: got addr=%0d data=%0d want 30 %0d", c, ram_waddr_o, ram_wdata_o, (c == 9) ? 1 : 0);
            end
         end
         cycle();
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      for (int c = 0; c < 3; c++) begin
         idle_inputs();
         pred_valid_i = 1'b1; upd_valid_i = 1'b1; upd_index_i = INDEX'(20 + c); upd_taken_i = 1'b1;
         #3;
         checks++; if (upd_ready_o !== 1'b1 || ram_we_o !== 1'b0) begin errors++; $display("FAIL mid_fill[%0d]: got ready=%b we=%b want 1 0", c, upd_ready_o, ram_we_o); end
         cycle();
      end
      idle_inputs(); reset = 1'b1;
      #3;
      checks++; if (ram_we_o !== 1'b0 || upd_ready_o !== 1'b0 || pred_ready_o !== 1'b0) begin errors++; $display("FAIL mid_reset: got we=%b upd=%b pred=%b want 0 0 0", ram_we_o, upd_ready_o, pred_ready_o); end
      cycle();
      reset = 1'b0;
      #3;
      checks++; if (init_done_o !== 1'b0) begin errors++; $display("FAIL mid_init_drop: got %b want 0", init_done_o); end
      for (int i = 0; i < DEPTH; i++) begin
         if (i != 0) #3;
         checks++;
         if (ram_we_o !== 1'b1 || ram_waddr_o !== INDEX'(i) || ram_wdata_o !== 2'd2) begin
            errors++; $display("FAIL mid_sweep[%0d]: got we=%b addr=%0d data=%0d want 1 %0d 2", i, ram_we_o, ram_waddr_o, ram_wdata_o, i);
         end
         cycle();
      end
      #3;
      checks++; if (init_done_o !== 1'b1) begin errors++; $display("FAIL mid_init_done: got %b want 1", init_done_o); end
      for (int c = 0; c < 6; c++) begin
         if (c != 0) #3;
         checks++; if (ram_we_o !== 1'b0) begin errors++; $display("FAIL mid_no_write[%0d]: got addr=%0d want no write", c, ram_waddr_o); end
         cycle();
      end
      for (int i = 20; i < 23; i++) begin
         checks++; if (ram[i] !== 2'd2) begin errors++; $display("FAIL mid_ram[%0d]: got %0d want 2", i, ram[i]); end
      end
   endtask

   task automatic test_random();
      int tbl [DEPTH];
      int mq_idx[$];
      int mq_tk[$];
      int starve, v, hi;
      bit force_m, grant_m, acc;
      idle_inputs();
      reset = 1'b1; cycle(); reset = 1'b0;
      for (int i = 0; i < DEPTH; i++) cycle();
      #3;
      checks++; if (init_done_o !== 1'b1) begin errors++; $display("FAIL rnd_init_done: got %b want 1", init_done_o); end
      cycle();
      for (int i = 0; i < DEPTH; i++) tbl[i] = 2;
      starve = 0;
      for (int c = 0; c < 900; c++) begin
         hi = (c < 890) ? 1 : 0;
         pred_valid_i = hi[0] && ($urandom_range(0, 99) < 80);
         pred_index_i = INDEX'($urandom_range(0, 7));
         upd_valid_i  = hi[0] && ($urandom_range(0, 99) < 45);
         upd_index_i  = INDEX'($urandom_range(0, 7));
         upd_taken_i  = ($urandom_range(0, 99) < 60);
         #3;
         force_m = (starve == SLIM);
         grant_m = (mq_idx.size() > 0) && (!pred_valid_i || force_m);
         acc     = upd_valid_i && (mq_idx.size() < QDEPTH);
         checks++; if (pred_ready_o !== !force_m) begin errors++; $display("FAIL rnd_pred_ready[%0d]: got %b want %b", c, pred_ready_o, !force_m); end
         checks++; if (upd_ready_o !== (mq_idx.size() < QDEPTH)) begin errors++; $display("FAIL rnd_upd_ready[%0d]: got %b want %b", c, upd_ready_o, (mq_idx.size() < QDEPTH)); end
         checks++; if (ram_we_o !== grant_m) begin errors++; $display("FAIL rnd_we[%0d]: got %b want %b", c, ram_we_o, grant_m); end
         if (pred_valid_i && !force_m) begin
            checks++;
            if (pred_ctr_o !== WIDTH'(tbl[pred_index_i]) || pred_taken_o !== (tbl[pred_index_i] >= 2)) begin
               errors++; $display("FAIL rnd_lookup[%0d]: got ctr=%0d taken=%b want ctr=%0d", c, pred_ctr_o, pred_taken_o, tbl[pred_index_i]);
            end
         end
         if (grant_m) begin
            v = tbl[mq_idx[0]] + ((mq_tk[0] != 0) ? 1 : -1);
            if (v > 3) v = 3;
            if (v < 0) v = 0;
            checks++;
            if (ram_waddr_o !== INDEX'(mq_idx[0]) || ram_wdata_o !== WIDTH'(v)) begin
               errors++; $display("FAIL rnd_write[%0d]: got addr=%0d data=%0d want %0d %0d", c, ram_waddr_o, ram_wdata_o, mq_idx[0], v);
            end
            tbl[mq_idx[0]] = v;
            void'(mq_idx.pop_front());
            void'(mq_tk.pop_front());
            starve = 0;
         end else if (mq_idx.size() > 0 && pred_valid_i) begin
            starve++;
         end
         if (acc) begin
            mq_idx.push_back(int'(upd_index_i));
            mq_tk.push_back(upd_taken_i ? 1 : 0);
         end
         cycle();
      end
      idle_inputs();
      checks++; if (mq_idx.size() != 0) begin errors++; $display("FAIL rnd_drain: got %0d pending want 0", mq_idx.size()); end
      for (int i = 0; i < DEPTH; i++) begin
         checks++; if (ram[i] !== WIDTH'(tbl[i])) begin errors++; $display("FAIL rnd_table[%0d]: got %0d want %0d", i, ram[i], tbl[i]); end
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset = 1'b1;
      idle_inputs();
      cycle();
      test_reset();
      test_saturation();
      test_queue_full();
      test_starvation();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
